// File: rtl/pulse_sched_if.sv
// Bundle of configuration, control and status signals between a pulse_sched
// instance and the logic that programs and observes it.
interface pulse_sched_if #(
  parameter int CNT_W  = 12,
  parameter int WID_W  = 8,
  parameter int PCNT_W = 8
);
  logic [1:0]        cfg_mode;
  logic [CNT_W-1:0]  cfg_delay;
  logic [WID_W-1:0]  cfg_width;
  logic              arm;
  logic              finished;
  logic              abort;
  logic              pulse;
  logic              pulse_rise;
  logic              busy;
  logic [PCNT_W-1:0] pulse_cnt;

  modport master (
    output cfg_mode, cfg_delay, cfg_width, arm, finished, abort,
    input  pulse, pulse_rise, busy, pulse_cnt
  );

  modport slave (
    input  cfg_mode, cfg_delay, cfg_width, arm, finished, abort,
    output pulse, pulse_rise, busy, pulse_cnt
  );
endinterface

// File: rtl/pulse_sched.sv
// Start-pulse scheduler: programmable delay, then a level or fixed-width pulse,
// optionally repeating; arms itself once out of reset when AUTO_START is set.
module pulse_sched #(
  parameter int               CNT_W      = 12,
  parameter int               WID_W      = 8,
  parameter logic [CNT_W-1:0] INIT_DELAY = 12'hffc,
  parameter bit               AUTO_START = 1'b1,
  parameter int               PCNT_W     = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  pulse_sched_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WID_W-1:0]  WID_ZERO  = {WID_W{1'b0}};
  localparam logic [WID_W-1:0]  WID_ONE   = {{(WID_W-1){1'b0}}, 1'b1};
  localparam logic [PCNT_W-1:0] PCNT_ZERO = {PCNT_W{1'b0}};
  localparam logic [PCNT_W-1:0] PCNT_ONE  = {{(PCNT_W-1){1'b0}}, 1'b1};

  state_t            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [WID_W-1:0]  wcnt_r;
  logic [1:0]        mode_r;
  logic              pulse_r;
  logic              rise_r;
  logic              busy_r;
  logic [PCNT_W-1:0] pcnt_r;
  logic [WID_W-1:0]  width_ld_s;
  logic              active_end_s;

  // Width load value and end-of-active condition (mode_r bit0 selects WIDTH).
  always_comb begin
    width_ld_s   = (bus.cfg_width == WID_ZERO) ? WID_ONE : bus.cfg_width;
    active_end_s = bus.finished || (mode_r[0] && (wcnt_r == WID_ONE));
  end

  // Scheduler state machine with registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r <= AUTO_START ? ST_DELAY : ST_IDLE;
      cnt_r   <= AUTO_START ? INIT_DELAY : CNT_ZERO;
      busy_r  <= AUTO_START;
      wcnt_r  <= WID_ZERO;
      mode_r  <= 2'b00;
      pulse_r <= 1'b0;
      rise_r  <= 1'b0;
      pcnt_r  <= PCNT_ZERO;
    end else begin
      rise_r <= 1'b0;
      if (bus.abort) begin
        state_r <= ST_IDLE;
        busy_r  <= 1'b0;
        pulse_r <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            // finished in the same cycle suppresses a pending arm
            if (bus.arm && !bus.finished) begin
              mode_r  <= bus.cfg_mode;
              cnt_r   <= bus.cfg_delay;
              state_r <= ST_DELAY;
              busy_r  <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_DELAY: begin
            if (bus.finished) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end else if (cnt_r == CNT_ZERO) begin
              state_r <= ST_ACTIVE;
              pulse_r <= 1'b1;
              rise_r  <= 1'b1;
              pcnt_r  <= pcnt_r + PCNT_ONE;
              wcnt_r  <= width_ld_s;
            end else begin
              cnt_r <= cnt_r - CNT_ONE;
            end
          end
          ST_ACTIVE: begin
            if (active_end_s) begin
              pulse_r <= 1'b0;
              if (mode_r[1]) begin
                cnt_r   <= bus.cfg_delay;
                state_r <= ST_DELAY;
              end else begin
                state_r <= ST_IDLE;
                busy_r  <= 1'b0;
              end
            end else if (mode_r[0] && (wcnt_r != WID_ZERO)) begin
              wcnt_r <= wcnt_r - WID_ONE;
            end else begin
              wcnt_r <= wcnt_r;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            pulse_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.pulse      = pulse_r;
  assign bus.pulse_rise = rise_r;
  assign bus.busy       = busy_r;
  assign bus.pulse_cnt  = pcnt_r;

endmodule
